// File: rtl/shmem_arbiter.sv
// Round-robin arbiter between N_PROC proc units and one single-port shared memory.
// One owner holds the memory at a time. Grants are registered. The memory address,
// write data and write size are muxed combinationally from the owner's slice.
// A hold limit hands the memory to a waiting proc after MAX_HOLD consecutive cycles.
module shmem_arbiter #(
  parameter int N_PROC   = 4,
  parameter int MAX_HOLD = 8,
  parameter int ADDR_W   = 32,
  parameter int BUS_W    = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic [N_PROC-1:0]              i_req_rd,
  input  logic [N_PROC-1:0]              i_req_wr,
  input  logic [N_PROC*ADDR_W-1:0]       i_addr,
  input  logic [N_PROC*BUS_W-1:0]        i_wdata,
  input  logic [N_PROC*3-1:0]            i_wr_size,
  output logic [N_PROC-1:0]              o_grant_rd,
  output logic [N_PROC-1:0]              o_grant_wr,
  output logic                           o_mem_re,
  output logic                           o_mem_we,
  output logic [ADDR_W-1:0]              o_mem_addr,
  output logic [BUS_W-1:0]               o_mem_wdata,
  output logic [2:0]                     o_mem_wr_size,
  input  logic [BUS_W-1:0]               i_mem_rdata,
  output logic [BUS_W-1:0]               o_rdata,
  output logic [$clog2(N_PROC)-1:0]      o_owner,
  output logic                           o_busy
);

  localparam int OWN_W = $clog2(N_PROC);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // Registered arbitration state.
  state_t           state_q, state_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [OWN_W-1:0] ptr_q, ptr_d;
  logic             is_wr_q, is_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Request decoding and arbitration results.
  logic [N_PROC-1:0] pending;
  logic [N_PROC-1:0] others;
  logic              owner_same;
  logic              found_all, found_oth;
  logic [OWN_W-1:0]  win_all, win_oth;
  logic              grant_new;
  logic [OWN_W-1:0]  grant_idx;
  logic [N_PROC-1:0] owner_oh;

  // Round-robin search: first set bit of mask strictly after 'last', wrapping,
  // so 'last' itself is checked at the very end (lowest priority).
  function automatic void rr_pick(
    input  logic [N_PROC-1:0] mask,
    input  logic [OWN_W-1:0]  last,
    output logic              found,
    output logic [OWN_W-1:0]  win
  );
    int               idx;
    logic [OWN_W-1:0] idx_b;
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= N_PROC; i++) begin
      idx = int'(last) + i;
      if (idx >= N_PROC) idx = idx - N_PROC;
      idx_b = OWN_W'(idx);
      if (!found && mask[idx_b]) begin
        found = 1'b1;
        win   = idx_b;
      end
    end
  endfunction

  // Decode pending requests and run both arbitration searches.
  // NOTE: every variable written in an always_comb gets a value at the top of the block, so no path can infer a latch.
  always_comb begin
    pending    = i_req_rd | i_req_wr;
    others     = pending & ~(N_PROC'(1) << owner_q);
    owner_same = pending[owner_q] && (i_req_wr[owner_q] == is_wr_q);
    rr_pick(pending, ptr_q, found_all, win_all);
    rr_pick(others, owner_q, found_oth, win_oth);
  end

  // Next-state logic: keep, hand over on hold limit, re-arbitrate, or go idle.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    is_wr_d   = is_wr_q;
    cnt_d     = cnt_q;
    grant_new = 1'b0;
    grant_idx = win_all;
    case (state_q)
      ST_IDLE: begin
        grant_new = found_all;
      end
      ST_OWN: begin
        if (owner_same) begin
          if (!(|others)) begin
            // Alone on the bus: keep going, counter saturates.
            if (cnt_q != HOLD_MAX) cnt_d = cnt_q + 1'b1;
          end else if (cnt_q < HOLD_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            // Hold limit reached with others waiting: owner is excluded.
            grant_new = found_oth;
            grant_idx = win_oth;
          end
        end else if (found_all) begin
          // Owner released or switched type; it competes at lowest priority.
          grant_new = 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (grant_new) begin
      state_d = ST_OWN;
      owner_d = grant_idx;
      ptr_d   = grant_idx;
      is_wr_d = i_req_wr[grant_idx];
      cnt_d   = CNT_W'(1);
    end
  end

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= OWN_W'(N_PROC - 1);
      is_wr_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      is_wr_q <= is_wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant vectors and memory-port mux driven from the registered owner.
  always_comb begin
    o_busy        = (state_q == ST_OWN);
    o_owner       = owner_q;
    owner_oh      = o_busy ? (N_PROC'(1) << owner_q) : '0;
    o_grant_wr    = is_wr_q ? owner_oh : '0;
    o_grant_rd    = is_wr_q ? '0 : owner_oh;
    o_mem_re      = |o_grant_rd;
    o_mem_we      = |o_grant_wr;
    o_mem_addr    = '0;
    o_mem_wdata   = '0;
    o_mem_wr_size = '0;
    if (o_busy) begin
      o_mem_addr    = i_addr[int'(owner_q)*ADDR_W +: ADDR_W];
      o_mem_wdata   = i_wdata[int'(owner_q)*BUS_W +: BUS_W];
      o_mem_wr_size = i_wr_size[int'(owner_q)*3 +: 3];
    end
    o_rdata = i_mem_rdata;
  end

  a_re_we_excl: assert property (@(posedge i_clk) disable iff (!i_rstn)
    !(o_mem_re && o_mem_we));
  a_grant_onehot: assert property (@(posedge i_clk) disable iff (!i_rstn)
    $onehot0(o_grant_rd | o_grant_wr));

endmodule

// File: tb/tb_shmem_arbiter.sv
// Self-checking bench for shmem_arbiter: directed scenarios plus a randomized phase,
// all cycles scored against a queue-based reference model.
module tb_shmem_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 8;
  localparam int AW   = 32;
  localparam int BW   = 64;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_rd = '0;
  logic [N-1:0]    req_wr = '0;
  logic [AW-1:0]   addr_a  [N];
  logic [BW-1:0]   wdata_a [N];
  logic [2:0]      size_a  [N];
  logic [N*AW-1:0] addr_flat;
  logic [N*BW-1:0] wdata_flat;
  logic [N*3-1:0]  size_flat;
  logic [BW-1:0]   mem_rdata = '0;

  logic [N-1:0]    o_grant_rd, o_grant_wr;
  logic            o_mem_re, o_mem_we, o_busy;
  logic [AW-1:0]   o_mem_addr;
  logic [BW-1:0]   o_mem_wdata, o_rdata;
  logic [2:0]      o_mem_wr_size;
  logic [1:0]      o_owner;

  int n_checks = 0;
  int n_err    = 0;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      addr_flat[k*AW +: AW]  = addr_a[k];
      wdata_flat[k*BW +: BW] = wdata_a[k];
      size_flat[k*3 +: 3]    = size_a[k];
    end
  end

  shmem_arbiter #(.N_PROC(N), .MAX_HOLD(MAXH), .ADDR_W(AW), .BUS_W(BW)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_req_rd(req_rd), .i_req_wr(req_wr),
    .i_addr(addr_flat), .i_wdata(wdata_flat), .i_wr_size(size_flat),
    .o_grant_rd(o_grant_rd), .o_grant_wr(o_grant_wr),
    .o_mem_re(o_mem_re), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wr_size(o_mem_wr_size),
    .i_mem_rdata(mem_rdata), .o_rdata(o_rdata),
    .o_owner(o_owner), .o_busy(o_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [N-1:0]  grd;
    logic [N-1:0]  gwr;
    logic          busy;
    int            owner;
    logic          re;
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    logic [2:0]    size;
  } exp_t;

  exp_t exp_q[$];
  bit   m_busy = 0;
  bit   m_wr   = 0;
  int   m_owner = 0;
  int   m_cnt   = 0;
  int   m_ptr   = N - 1;

  function automatic bit is_pend(int k);
    return (req_rd[k] || req_wr[k]);
  endfunction

  // First pending proc after 'from' (wrapping, 'from' checked last), skipping 'excl'.
  function automatic int first_pending(int from, int excl);
    int k;
    for (int i = 1; i <= N; i++) begin
      k = (from + i) % N;
      if (k != excl && is_pend(k)) return k;
    end
    return -1;
  endfunction

  task automatic take(int w);
    m_busy  = 1;
    m_owner = w;
    m_ptr   = w;
    m_wr    = req_wr[w];
    m_cnt   = 1;
  endtask

  // Model advances on every edge and queues the outputs expected after it.
  always @(posedge clk) begin
    exp_t e;
    int   w;
    bit   oth;
    if (!rstn) begin
      m_busy = 0; m_wr = 0; m_owner = 0; m_cnt = 0; m_ptr = N - 1;
    end else if (!m_busy) begin
      w = first_pending(m_ptr, -1);
      if (w >= 0) take(w);
    end else begin
      oth = 0;
      for (int k = 0; k < N; k++) if (k != m_owner && is_pend(k)) oth = 1;
      if (is_pend(m_owner) && (req_wr[m_owner] == m_wr)) begin
        if (!oth) m_cnt = (m_cnt < MAXH) ? m_cnt + 1 : MAXH;
        else if (m_cnt < MAXH) m_cnt = m_cnt + 1;
        else take(first_pending(m_owner, m_owner));
      end else begin
        w = first_pending(m_owner, -1);
        if (w >= 0) take(w);
        else begin m_busy = 0; m_cnt = 0; end
      end
    end
    e.busy  = m_busy;
    e.owner = m_owner;
    e.grd   = (m_busy && !m_wr) ? N'(1 << m_owner) : '0;
    e.gwr   = (m_busy &&  m_wr) ? N'(1 << m_owner) : '0;
    e.re    = m_busy && !m_wr;
    e.we    = m_busy && m_wr;
    e.addr  = m_busy ? addr_a[m_owner]  : '0;
    e.wdata = m_busy ? wdata_a[m_owner] : '0;
    e.size  = m_busy ? size_a[m_owner]  : '0;
    exp_q.push_back(e);
  end

  // Monitor: sample 1 time unit after the edge and score against the queue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL sb_underflow: got empty queue expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("grant_rd", 64'(o_grant_rd), 64'(e.grd));
      check("grant_wr", 64'(o_grant_wr), 64'(e.gwr));
      check("busy", 64'(o_busy), 64'(e.busy));
      if (e.busy) check("owner", 64'(o_owner), 64'(e.owner));
      check("mem_re", 64'(o_mem_re), 64'(e.re));
      check("mem_we", 64'(o_mem_we), 64'(e.we));
      check("mem_addr", 64'(o_mem_addr), 64'(e.addr));
      check("mem_wdata", o_mem_wdata, e.wdata);
      check("mem_wr_size", 64'(o_mem_wr_size), 64'(e.size));
      check("rdata", o_rdata, mem_rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic r, input logic [N-1:0] rd, input logic [N-1:0] wr);
    @(negedge clk);
    rstn   = r;
    req_rd = rd;
    req_wr = wr;
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      addr_a[k]  = AW'(32'h100 * (k + 1));
      wdata_a[k] = {$urandom, $urandom};
      size_a[k]  = 3'(k);
    end

    // 1: grant after reset, then hand-over without a gap
    step(1'b0, 4'b0000, 4'b0000);
    step(1'b0, 4'b0000, 4'b0000);
    check("t1_reset_busy", 64'(o_busy), 64'd0);
    check("t1_reset_grants", 64'({o_grant_rd, o_grant_wr}), 64'd0);
    step(1'b1, 4'b0101, 4'b0000);
    check("t1_first_grant", 64'(o_grant_rd), 64'b0001);
    step(1'b1, 4'b0100, 4'b0000);
    check("t1_handover", 64'(o_grant_rd), 64'b0100);
    step(1'b1, 4'b0000, 4'b0000);
    check("t1_release", 64'(o_busy), 64'd0);

    // 2: all procs read continuously, each gets exactly MAXH cycles in turn
    step(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 4'b1111, 4'b0000);
      check("t2_rotation", 64'(o_grant_rd), 64'(4'b0001 << ((i / MAXH) % N)));
    end
    step(1'b1, 4'b0000, 4'b0000);

    // 3: lone writer keeps the grant past the hold limit
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'b0000, 4'b0100);
      check("t3_lone_wr", 64'({o_grant_rd, o_grant_wr}), 64'({4'b0000, 4'b0100}));
    end
    step(1'b1, 4'b0000, 4'b0000);
    check("t3_idle_after", 64'(o_busy), 64'd0);

    // 4: rd+wr together gives the write; dropping wr re-grants the read
    step(1'b1, 4'b0010, 4'b0010);
    check("t4_wr_wins", 64'({o_grant_rd, o_grant_wr}), 64'({4'b0000, 4'b0010}));
    step(1'b1, 4'b0010, 4'b0000);
    check("t4_rd_after", 64'({o_grant_rd, o_grant_wr}), 64'({4'b0010, 4'b0000}));
    step(1'b1, 4'b0000, 4'b0000);

    // 5: proc3 write routes its address, data and size
    addr_a[3]  = 32'h40;
    wdata_a[3] = 64'hA5A5_A5A5_A5A5_A5A5;
    size_a[3]  = 3'd2;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0000, 4'b1000);
      check("t5_we", 64'({o_mem_we, o_mem_re}), 64'b10);
      check("t5_addr", 64'(o_mem_addr), 64'h40);
      check("t5_size", 64'(o_mem_wr_size), 64'd2);
      check("t5_wdata", o_mem_wdata, 64'hA5A5_A5A5_A5A5_A5A5);
    end
    step(1'b1, 4'b0000, 4'b0000);
    check("t5_we_off", 64'({o_mem_we, o_mem_re}), 64'b00);
    check("t5_addr_off", 64'(o_mem_addr), 64'd0);

    // 6: reset mid-grant drops it; proc0 wins first after release
    step(1'b1, 4'b0000, 4'b0010);
    check("t6_owns", 64'(o_grant_wr), 64'b0010);
    step(1'b0, 4'b0000, 4'b0010);
    check("t6_rst_grants", 64'({o_grant_rd, o_grant_wr}), 64'd0);
    check("t6_rst_we", 64'(o_mem_we), 64'd0);
    step(1'b1, 4'b0011, 4'b0000);
    check("t6_p0_first", 64'(o_grant_rd), 64'b0001);

    // Randomized phase with sticky requests and occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rstn = ($urandom_range(0, 299) != 0);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 9) == 0)  req_rd[k] = ~req_rd[k];
        if ($urandom_range(0, 11) == 0) req_wr[k] = ~req_wr[k];
        addr_a[k]  = $urandom;
        wdata_a[k] = {$urandom, $urandom};
        size_a[k]  = 3'($urandom_range(0, 4));
      end
      mem_rdata = {$urandom, $urandom};
    end
    @(posedge clk);
    #3;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
